// File: rtl/sequence_generator.sv
// ----------------------------------------------------------------------------
// sequence_generator
//
// Pattern source for the Simon game. A free-running Galois LFSR supplies
// random values. On start, DEPTH values of VAL_W bits are captured into an
// internal buffer. The buffer is then streamed out one value at a time over a
// valid/ready handshake. On replay, the buffer is streamed again without
// refilling, so the game can re-show the same sequence each round.
//
// Optional build macro:
//   SEQGEN_NONZERO_EN - when defined, FILL never writes a captured value of 0.
//                       The LFSR still steps and the fill index holds, so FILL
//                       may take more than DEPTH cycles. When undefined, every
//                       captured value is written, including 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   seed_load  in   load seed_in into the LFSR (accepted in IDLE only)
//   seed_in    in   [LFSR_W-1:0] seed value (0 is replaced by SEED)
//   start      in   pulse: fill the buffer, then stream it
//   replay     in   pulse: stream the existing buffer without a refill
//   out_valid  out  out_data/out_index/out_last are valid
//   out_ready  in   consumer accepts the current value
//   out_data   out  [VAL_W-1:0] current sequence value
//   out_index  out  [$clog2(DEPTH)-1:0] buffer index of out_data
//   out_last   out  out_index == DEPTH-1 while out_valid
//   busy       out  FSM is not in IDLE
//   done       out  one-cycle pulse after the final handshake
//   state_dbg  out  [1:0] current FSM state (IDLE=0, FILL=1, STREAM=2, DONE=3)
//
// Handshake: a value transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0, out_data,
// out_index and out_last hold their values. out_valid never drops without a
// transfer, and out_ready has no effect outside STREAM.
// ----------------------------------------------------------------------------
module sequence_generator #(
  parameter int                VAL_W     = 6,
  parameter int                DEPTH     = 5,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003,
  parameter logic [LFSR_W-1:0] SEED      = 32'hACE1_2345
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       seed_load,
  input  logic [LFSR_W-1:0]          seed_in,
  input  logic                       start,
  input  logic                       replay,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [VAL_W-1:0]           out_data,
  output logic [$clog2(DEPTH)-1:0]   out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // --------------------------------------------------------------------------
  // Datapath storage
  // --------------------------------------------------------------------------
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_step;
  logic [VAL_W-1:0]  buffer_q [DEPTH];
  logic [IDX_W-1:0]  fill_idx_q;
  logic [IDX_W-1:0]  stream_idx_q;
  logic              filled_q;

  // --------------------------------------------------------------------------
  // Decoded control
  // --------------------------------------------------------------------------
  logic [VAL_W-1:0]  capture;     // pre-step LFSR low bits
  logic              seed_accept; // seed load taken this cycle
  logic              fill_wr;     // buffer write this cycle
  logic              fill_last;   // this write lands in the final slot
  logic              stream_last; // stream index is at the final slot
  logic              xfer;        // handshake completes this cycle

  // Galois right-shift step: fold the taps in when the bit shifted out is 1.
  always_comb begin
    lfsr_step = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_step = (lfsr_q >> 1) ^ LFSR_TAPS;
    end
  end

  assign capture     = lfsr_q[VAL_W-1:0];
  assign seed_accept = (state_q == IDLE) && seed_load;
  assign stream_last = (stream_idx_q == LAST_IDX);
  assign xfer        = (state_q == STREAM) && out_ready;

`ifdef SEQGEN_NONZERO_EN
  // A zero capture is skipped: nothing is written and the index holds.
  assign fill_wr = (state_q == FILL) && (capture != '0);
`else
  assign fill_wr = (state_q == FILL);
`endif

  assign fill_last = fill_wr && (fill_idx_q == LAST_IDX);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // In IDLE, seed_load outranks start, which outranks replay; a lower-priority
  // request arriving with a higher one is dropped.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = FILL;
        end else if (replay && filled_q) begin
          state_d = STREAM;
        end
      end
      FILL: begin
        if (fill_last) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && stream_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // Data and index are forced to 0 outside STREAM so the bus is quiet
  // whenever out_valid is low.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    state_dbg = state_q;
    unique case (state_q)
      IDLE: begin
      end
      FILL: begin
      end
      STREAM: begin
        out_valid = 1'b1;
        out_data  = buffer_q[stream_idx_q];
        out_index = stream_idx_q;
        out_last  = stream_last;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // LFSR: steps every cycle except the one in which a seed is accepted.
  // A zero seed would lock the LFSR at 0, so SEED is substituted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (seed_accept) begin
      lfsr_q <= (seed_in == '0) ? SEED : seed_in;
    end else begin
      lfsr_q <= lfsr_step;
    end
  end

  // --------------------------------------------------------------------------
  // Fill index: parked at 0 outside FILL, so every fill starts from slot 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_idx_q <= '0;
    end else if (state_q != FILL) begin
      fill_idx_q <= '0;
    end else if (fill_wr && !fill_last) begin
      fill_idx_q <= fill_idx_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer and filled flag. The flag stays set across later fills, so the
  // buffer always holds a complete sequence once any fill has finished.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buffer_q[i] <= '0;
      end
      filled_q <= 1'b0;
    end else begin
      if (fill_wr) begin
        buffer_q[fill_idx_q] <= capture;
      end
      if (fill_last) begin
        filled_q <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stream index: parked at 0 outside STREAM, so both a fresh fill and a
  // replay begin streaming at slot 0. It advances only on a completed
  // transfer, so a stalled consumer sees the same value until it accepts.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stream_idx_q <= '0;
    end else if (state_q != STREAM) begin
      stream_idx_q <= '0;
    end else if (xfer && !stream_last) begin
      stream_idx_q <= stream_idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;

  localparam int VAL_W  = 6;
  localparam int DEPTH  = 5;
  localparam int LFSR_W = 32;
  localparam int IDX_W  = $clog2(DEPTH);

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic              start;
  logic              replay;
  logic              out_valid;
  logic              out_ready;
  logic [VAL_W-1:0]  out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  sequence_generator #(
    .VAL_W     (VAL_W),
    .DEPTH     (DEPTH),
    .LFSR_W    (LFSR_W),
    .LFSR_TAPS (32'h8020_0003),
    .SEED      (32'hACE1_2345)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .start     (start),
    .replay    (replay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [VAL_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push5(input logic [VAL_W-1:0] a, b, c, d, e);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic load_seed(input logic [LFSR_W-1:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    step();
    seed_load = 1'b0;
    seed_in   = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called the cycle after start is accepted: expects n FILL cycles with
  // out_valid low, then out_valid high.
  task automatic wait_fill(input int n);
    for (int i = 0; i < n; i++) begin
      check("fill_busy", busy, 1);
      check("fill_no_valid", out_valid, 0);
      step();
    end
    check("first_valid", out_valid, 1);
  endtask

  // Drain DEPTH values against exp_q, optionally stalling at one index.
  task automatic consume_all(input int stall_at, input int stall_len);
    logic [VAL_W-1:0] exp_v;
    for (int k = 0; k < DEPTH; k++) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, exp_v);
          check("stall_index", out_index, k);
          step();
        end
      end
      out_ready = 1'b1;
      check("str_valid", out_valid, 1);
      check("str_data", out_data, exp_v);
      check("str_index", out_index, k);
      check("str_last", out_last, (k == DEPTH - 1) ? 1 : 0);
      check("str_no_done", done, 0);
      step();
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_no_valid", out_valid, 0);
    check("done_busy", busy, 1);
    step();
    check("done_cleared", done, 0);
    check("idle_busy", busy, 0);
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed_in   = '0;
    start     = 1'b0;
    replay    = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    // Reset values
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // Replay with nothing filled is ignored
    replay = 1'b1;
    step();
    replay = 1'b0;
    check("replay_empty_busy", busy, 0);
    check("replay_empty_valid", out_valid, 0);
    step();
    check("replay_empty_busy2", busy, 0);

    // Seed 1, ready held high: 3,2,1,3,2 after DEPTH fill cycles
    load_seed(32'h1);
    pulse_start();
    wait_fill(DEPTH);
    push5(6'd3, 6'd2, 6'd1, 6'd3, 6'd2);
    consume_all(-1, 0);

    // Same seed, 3-cycle stall at index 2
    load_seed(32'h1);
    pulse_start();
    wait_fill(DEPTH);
    push5(6'd3, 6'd2, 6'd1, 6'd3, 6'd2);
    consume_all(2, 3);

    // Replay: valid the cycle after the pulse, same sequence
    replay = 1'b1;
    step();
    replay = 1'b0;
    check("replay_valid", out_valid, 1);
    push5(6'd3, 6'd2, 6'd1, 6'd3, 6'd2);
    consume_all(-1, 0);

    // Seed 0x80: a zero lands in the first capture
    load_seed(32'h80);
    pulse_start();
`ifdef SEQGEN_NONZERO_EN
    wait_fill(DEPTH + 1);
    push5(6'd32, 6'd16, 6'd8, 6'd4, 6'd2);
`else
    wait_fill(DEPTH);
    push5(6'd0, 6'd32, 6'd16, 6'd8, 6'd4);
`endif
    consume_all(-1, 0);

    // Zero seed falls back to SEED = 0xACE12345 -> 33,19,42,53,25
    load_seed(32'h0);
    pulse_start();
    wait_fill(DEPTH);

    // Requests while streaming are ignored; stalled output holds
    out_ready = 1'b0;
    start     = 1'b1;
    replay    = 1'b1;
    seed_load = 1'b1;
    seed_in   = 32'h1;
    step();
    start     = 1'b0;
    replay    = 1'b0;
    seed_load = 1'b0;
    seed_in   = '0;
    check("busy_req_valid", out_valid, 1);
    check("busy_req_index", out_index, 0);
    check("busy_req_data", out_data, 33);

    out_ready = 1'b1;
    check("seed0_d0", out_data, 33);
    step();
    check("seed0_d1", out_data, 19);
    step();
    check("seed0_d2", out_data, 42);
    step();
    out_ready = 1'b0;
    check("seed0_d3", out_data, 53);
    check("seed0_i3", out_index, 3);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_index", out_index, 0);
    check("arst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();

    // Buffer no longer marked filled
    replay = 1'b1;
    step();
    replay = 1'b0;
    check("replay_after_rst_busy", busy, 0);
    check("replay_after_rst_valid", out_valid, 0);
    step();
    check("replay_after_rst_valid2", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
